// File: rtl/m68k_sdram_burst_controller.sv
// SDRAM responder for the 68k cache: 8-word burst reads, single-word writes, init and auto-refresh.
// Optional macro SDRAM_REFRESH_EN enables the periodic refresh timer and the Refresh state.
module m68k_sdram_burst_controller #(
  parameter int INIT_DELAY       = 5000,
  parameter int REFRESH_INTERVAL = 375,
  parameter int T_RCD            = 2,
  parameter int T_RP             = 2,
  parameter int T_RC             = 7,
  parameter int T_WR_RP          = 3
) (
  input  logic        Clock,
  input  logic        Reset_L,
  input  logic [31:0] AddressBusIn,
  input  logic [15:0] DataBusIn,
  output logic [15:0] DataBusOut,
  input  logic        DramSelect_L,
  input  logic        AS_L,
  input  logic        WE_L,
  input  logic        UDS_L,
  input  logic        LDS_L,
  output logic        Dtack_L,
  output logic        SDram_CKE_H,
  output logic        SDram_CS_L,
  output logic        SDram_RAS_L,
  output logic        SDram_CAS_L,
  output logic        SDram_WE_L,
  output logic [1:0]  SDram_BA,
  output logic [12:0] SDram_Addr,
  output logic [1:0]  SDram_DQM,
  output logic [15:0] SDram_DQ_Out,
  output logic        SDram_DQ_OE_H,
  input  logic [15:0] SDram_DQ_In,
  output logic [4:0]  ControllerState
);

  typedef enum logic [3:0] {
    CMD_LOAD_MODE = 4'b0000,
    CMD_REFRESH   = 4'b0001,
    CMD_PRECHARGE = 4'b0010,
    CMD_ACTIVE    = 4'b0011,
    CMD_WRITE     = 4'b0100,
    CMD_READ      = 4'b0101,
    CMD_NOP       = 4'b0111
  } cmd_e;

  typedef enum logic [4:0] {
    S_INIT_WAIT      = 5'd0,
    S_INIT_PRECHARGE = 5'd1,
    S_INIT_REFRESH1  = 5'd2,
    S_INIT_REFRESH2  = 5'd3,
    S_INIT_LOAD_MODE = 5'd4,
    S_IDLE           = 5'd5,
    S_REFRESH        = 5'd6,
    S_ACTIVATE       = 5'd7,
    S_READ_CMD       = 5'd8,
    S_READ_BURST     = 5'd9,
    S_WRITE_CMD      = 5'd10,
    S_WAIT_AS_HIGH   = 5'd11
  } state_e;

  // Each wait count is the number of NOP clocks that follow the state's command.
  localparam logic [15:0] INIT_CNT      = 16'(INIT_DELAY);
  localparam logic [15:0] RP_CNT        = 16'(T_RP);
  localparam logic [15:0] RC_CNT        = 16'(T_RC);
  localparam logic [15:0] RC_RUN_CNT    = 16'(T_RC - 1);
  localparam logic [15:0] RCD_CNT       = 16'(T_RCD - 1);
  localparam logic [15:0] READ_TAIL_CNT = 16'(8 + T_RP);
  localparam logic [15:0] WR_CNT        = 16'(T_WR_RP);
  localparam logic [12:0] MODE_WORD     = 13'h0223;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  cmd_e        cmd_q, cmd_d;
  logic [1:0]  ba_q, ba_d;
  logic [12:0] addr_q, addr_d;
  logic [1:0]  dqm_q, dqm_d;
  logic [15:0] dq_out_q, dq_out_d;
  logic        dq_oe_q, dq_oe_d;
  logic        dtack_l_q, dtack_l_d;
  logic        pending;
  logic        idle_go;

  logic [9:0]  col;
  logic [1:0]  bank;
  logic [12:0] row;
  logic        unused_addr;

  assign col         = AddressBusIn[10:1];
  assign bank        = AddressBusIn[12:11];
  assign row         = AddressBusIn[25:13];
  assign unused_addr = ^{AddressBusIn[31:26], AddressBusIn[0]};

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = CMD_NOP;
    ba_d      = ba_q;
    addr_d    = addr_q;
    dqm_d     = 2'b11;
    dq_out_d  = dq_out_q;
    dq_oe_d   = 1'b0;
    dtack_l_d = dtack_l_q;
    idle_go   = 1'b0;

    case (state_q)
      S_INIT_WAIT: begin
        if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
        else begin
          state_d = S_INIT_PRECHARGE;
          cmd_d   = CMD_PRECHARGE;
          addr_d  = 13'h0400;
          cnt_d   = RP_CNT;
        end
      end
      S_INIT_PRECHARGE: begin
        if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
        else begin
          state_d = S_INIT_REFRESH1;
          cmd_d   = CMD_REFRESH;
          cnt_d   = RC_CNT;
        end
      end
      S_INIT_REFRESH1: begin
        if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
        else begin
          state_d = S_INIT_REFRESH2;
          cmd_d   = CMD_REFRESH;
          cnt_d   = RC_CNT;
        end
      end
      S_INIT_REFRESH2: begin
        if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
        else begin
          state_d = S_INIT_LOAD_MODE;
          cmd_d   = CMD_LOAD_MODE;
          addr_d  = MODE_WORD;
          ba_d    = 2'b00;
          cnt_d   = 16'd2;
        end
      end
      S_INIT_LOAD_MODE: begin
        if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
        else state_d = S_IDLE;
      end
      S_IDLE: idle_go = 1'b1;
      S_REFRESH: begin
        // The last wait clock decides directly so ACTIVE lands exactly T_RC after REFRESH.
        if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
        else idle_go = 1'b1;
      end
      S_ACTIVATE: begin
        if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
        else if (WE_L) begin
          state_d   = S_READ_CMD;
          cmd_d     = CMD_READ;
          addr_d    = {2'b00, 1'b1, col};
          dqm_d     = 2'b00;
          dtack_l_d = 1'b0;
        end else begin
          state_d  = S_WRITE_CMD;
          cmd_d    = CMD_WRITE;
          addr_d   = {2'b00, 1'b1, col};
          dqm_d    = {UDS_L, LDS_L};
          dq_out_d = DataBusIn;
          dq_oe_d  = 1'b1;
          cnt_d    = WR_CNT;
        end
      end
      S_READ_CMD: begin
        state_d = S_READ_BURST;
        dqm_d   = 2'b00;
        cnt_d   = READ_TAIL_CNT;
      end
      S_READ_BURST: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
          dqm_d = 2'b00;
        end else state_d = S_WAIT_AS_HIGH;
      end
      S_WRITE_CMD: begin
        dtack_l_d = 1'b0;
        if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
        else state_d = S_WAIT_AS_HIGH;
      end
      S_WAIT_AS_HIGH: begin
        if (AS_L) begin
          state_d   = S_IDLE;
          dtack_l_d = 1'b1;
        end
      end
      default: begin
        state_d = S_INIT_WAIT;
        cnt_d   = INIT_CNT;
      end
    endcase

    if (idle_go) begin
      state_d = S_IDLE;
      if (pending) begin
        state_d = S_REFRESH;
        cmd_d   = CMD_REFRESH;
        cnt_d   = RC_RUN_CNT;
      end else if (!DramSelect_L && !AS_L) begin
        state_d = S_ACTIVATE;
        cmd_d   = CMD_ACTIVE;
        ba_d    = bank;
        addr_d  = row;
        cnt_d   = RCD_CNT;
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q   <= S_INIT_WAIT;
      cnt_q     <= INIT_CNT;
      cmd_q     <= CMD_NOP;
      ba_q      <= 2'b00;
      addr_q    <= 13'h0000;
      dqm_q     <= 2'b11;
      dq_out_q  <= 16'h0000;
      dq_oe_q   <= 1'b0;
      dtack_l_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      ba_q      <= ba_d;
      addr_q    <= addr_d;
      dqm_q     <= dqm_d;
      dq_out_q  <= dq_out_d;
      dq_oe_q   <= dq_oe_d;
      dtack_l_q <= dtack_l_d;
    end
  end

`ifdef SDRAM_REFRESH_EN
  localparam logic [15:0] REF_LAST = 16'(REFRESH_INTERVAL - 1);

  logic [15:0] tmr_q, tmr_d;
  logic        pending_q, pending_d;
  logic        tmr_run, tmr_expire, refresh_ack;

  always_comb begin
    tmr_run     = !(state_q inside {S_INIT_WAIT, S_INIT_PRECHARGE, S_INIT_REFRESH1,
                                    S_INIT_REFRESH2, S_INIT_LOAD_MODE});
    tmr_d       = tmr_q;
    tmr_expire  = 1'b0;
    if (tmr_run) begin
      if (tmr_q == REF_LAST) begin
        tmr_d      = 16'd0;
        tmr_expire = 1'b1;
      end else tmr_d = tmr_q + 16'd1;
    end
    refresh_ack = (state_d == S_REFRESH) && (cmd_d == CMD_REFRESH);
    // A single flag: an expiry while already pending is simply absorbed.
    pending_d   = tmr_expire | (pending_q & ~refresh_ack);
  end

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      tmr_q     <= 16'd0;
      pending_q <= 1'b0;
    end else begin
      tmr_q     <= tmr_d;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;
`else
  assign pending = 1'b0;
`endif

  assign DataBusOut      = SDram_DQ_In;
  assign Dtack_L         = dtack_l_q;
  assign SDram_CKE_H     = 1'b1;
  assign {SDram_CS_L, SDram_RAS_L, SDram_CAS_L, SDram_WE_L} = cmd_q;
  assign SDram_BA        = ba_q;
  assign SDram_Addr      = addr_q;
  assign SDram_DQM       = dqm_q;
  assign SDram_DQ_Out    = dq_out_q;
  assign SDram_DQ_OE_H   = dq_oe_q;
  assign ControllerState = state_q;

endmodule

// File: tb/tb_m68k_sdram_burst_controller.sv
// Directed bench for m68k_sdram_burst_controller: init, burst read, byte write, reset mid-burst,
// and (with SDRAM_REFRESH_EN) refresh cadence and refresh/request collision.
module tb_m68k_sdram_burst_controller;

  localparam logic [3:0] C_NOP       = 4'b0111;
  localparam logic [3:0] C_ACTIVE    = 4'b0011;
  localparam logic [3:0] C_READ      = 4'b0101;
  localparam logic [3:0] C_WRITE     = 4'b0100;
  localparam logic [3:0] C_PRECHARGE = 4'b0010;
  localparam logic [3:0] C_REFRESH   = 4'b0001;
  localparam logic [3:0] C_LOAD_MODE = 4'b0000;

  logic        Clock = 1'b0;
  logic        Reset_L;
  logic [31:0] AddressBusIn;
  logic [15:0] DataBusIn;
  logic [15:0] DataBusOut;
  logic        DramSelect_L, AS_L, WE_L, UDS_L, LDS_L;
  logic        Dtack_L;
  logic        SDram_CKE_H, SDram_CS_L, SDram_RAS_L, SDram_CAS_L, SDram_WE_L;
  logic [1:0]  SDram_BA;
  logic [12:0] SDram_Addr;
  logic [1:0]  SDram_DQM;
  logic [15:0] SDram_DQ_Out;
  logic        SDram_DQ_OE_H;
  logic [15:0] SDram_DQ_In;
  logic [4:0]  ControllerState;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] cmd_obs;
  assign cmd_obs = {SDram_CS_L, SDram_RAS_L, SDram_CAS_L, SDram_WE_L};

  m68k_sdram_burst_controller dut (
    .Clock(Clock), .Reset_L(Reset_L), .AddressBusIn(AddressBusIn), .DataBusIn(DataBusIn),
    .DataBusOut(DataBusOut), .DramSelect_L(DramSelect_L), .AS_L(AS_L), .WE_L(WE_L),
    .UDS_L(UDS_L), .LDS_L(LDS_L), .Dtack_L(Dtack_L), .SDram_CKE_H(SDram_CKE_H),
    .SDram_CS_L(SDram_CS_L), .SDram_RAS_L(SDram_RAS_L), .SDram_CAS_L(SDram_CAS_L),
    .SDram_WE_L(SDram_WE_L), .SDram_BA(SDram_BA), .SDram_Addr(SDram_Addr),
    .SDram_DQM(SDram_DQM), .SDram_DQ_Out(SDram_DQ_Out), .SDram_DQ_OE_H(SDram_DQ_OE_H),
    .SDram_DQ_In(SDram_DQ_In), .ControllerState(ControllerState)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_tests++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advances at least one clock, stopping at the first negedge where the command equals want.
  task automatic wait_cmd(input logic [3:0] want, input int limit, output int n);
    n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (cmd_obs !== want && n < limit);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_cmd"},   32'(cmd_obs),       32'(C_NOP));
    check({pfx, "_cke"},   32'(SDram_CKE_H),   32'd1);
    check({pfx, "_ba"},    32'(SDram_BA),      32'd0);
    check({pfx, "_addr"},  32'(SDram_Addr),    32'd0);
    check({pfx, "_dqm"},   32'(SDram_DQM),     32'b11);
    check({pfx, "_dqout"}, 32'(SDram_DQ_Out),  32'd0);
    check({pfx, "_oe"},    32'(SDram_DQ_OE_H), 32'd0);
    check({pfx, "_dtack"}, 32'(Dtack_L),       32'd1);
  endtask

  task automatic bus_idle();
    DramSelect_L = 1'b1;
    AS_L         = 1'b1;
    WE_L         = 1'b1;
    UDS_L        = 1'b1;
    LDS_L        = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    logic [15:0] beat;

    Reset_L      = 1'b0;
    AddressBusIn = 32'h0;
    DataBusIn    = 16'h0;
    SDram_DQ_In  = 16'h0;
    bus_idle();

    // Reset state
    repeat (3) @(negedge Clock);
    check_reset_outputs("rst");

    // Init: NOPs after release, then PRECHARGE ALL, two REFRESHes, LOAD MODE.
    Reset_L = 1'b1;
    wait_cmd(C_PRECHARGE, 6000, n);
    check("init_precharge_cmd", 32'(cmd_obs), 32'(C_PRECHARGE));
    check("init_nop_clocks", n, 5000 + 1);
    check("init_precharge_a10", 32'(SDram_Addr[10]), 32'd1);
    wait_cmd(C_REFRESH, 20, n);
    check("init_ref1_cmd", 32'(cmd_obs), 32'(C_REFRESH));
    check("init_ref1_gap", n, 3);
    wait_cmd(C_REFRESH, 20, n);
    check("init_ref2_cmd", 32'(cmd_obs), 32'(C_REFRESH));
    check("init_ref2_gap", n, 8);
    wait_cmd(C_LOAD_MODE, 20, n);
    check("init_lmr_cmd", 32'(cmd_obs), 32'(C_LOAD_MODE));
    check("init_lmr_gap", n, 8);
    check("init_lmr_addr", 32'(SDram_Addr), 32'h0223);
    check("init_lmr_ba", 32'(SDram_BA), 32'd0);
    repeat (4) @(negedge Clock);

`ifndef SDRAM_REFRESH_EN
    // With the timer removed the idle bus must stay silent.
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge Clock);
      if (cmd_obs !== C_NOP) bad++;
    end
    check("idle_no_commands", bad, 0);
`else
    // Refresh cadence on an idle bus.
    wait_cmd(C_REFRESH, 400, n);
    check("cad_first_ref", 32'(cmd_obs), 32'(C_REFRESH));
    wait_cmd(C_REFRESH, 400, n);
    check("cad_ref_cmd", 32'(cmd_obs), 32'(C_REFRESH));
    check("cad_period", n, 375);

    // Refresh collision: request arrives in the Idle cycle that sees pending.
    repeat (374) @(negedge Clock);
    AddressBusIn = 32'h0080_2A30;
    WE_L = 1'b1; UDS_L = 1'b0; LDS_L = 1'b0;
    DramSelect_L = 1'b0; AS_L = 1'b0;
    @(negedge Clock);
    check("col_refresh_first", 32'(cmd_obs), 32'(C_REFRESH));
    wait_cmd(C_ACTIVE, 20, n);
    check("col_active_cmd", 32'(cmd_obs), 32'(C_ACTIVE));
    check("col_active_gap", n, 7);
    repeat (20) @(negedge Clock);
    bus_idle();
    repeat (3) @(negedge Clock);
`endif

    // Burst read
    AddressBusIn = 32'h0080_2A30;
    WE_L = 1'b1; UDS_L = 1'b0; LDS_L = 1'b0;
    DramSelect_L = 1'b0; AS_L = 1'b0;
    wait_cmd(C_ACTIVE, 400, n);
    check("rd_active_cmd", 32'(cmd_obs), 32'(C_ACTIVE));
`ifndef SDRAM_REFRESH_EN
    check("rd_active_latency", n, 1);
`endif
    check("rd_active_row", 32'(SDram_Addr), 32'h0401);
    check("rd_active_ba", 32'(SDram_BA), 32'd1);
    @(negedge Clock);
    check("rd_rcd_nop", 32'(cmd_obs), 32'(C_NOP));
    check("rd_dtack_before", 32'(Dtack_L), 32'd1);
    @(negedge Clock);
    check("rd_read_cmd", 32'(cmd_obs), 32'(C_READ));
    check("rd_read_addr", 32'(SDram_Addr), 32'h0518);
    check("rd_read_ba", 32'(SDram_BA), 32'd1);
    check("rd_read_dqm", 32'(SDram_DQM), 32'b00);
    check("rd_read_dtack", 32'(Dtack_L), 32'd0);
    @(negedge Clock);
    for (int k = 0; k < 8; k++) begin
      @(posedge Clock);
      #1;
      beat = 16'h1111 * 16'(k + 1);
      SDram_DQ_In = beat;
      @(negedge Clock);
      check($sformatf("rd_beat%0d_data", k), 32'(DataBusOut), 32'(beat));
      check($sformatf("rd_beat%0d_dtack", k), 32'(Dtack_L), 32'd0);
      check($sformatf("rd_beat%0d_dqm", k), 32'(SDram_DQM), 32'b00);
    end
    repeat (6) @(negedge Clock);
    check("rd_hold_dtack", 32'(Dtack_L), 32'd0);
    check("rd_hold_no_reactivate", 32'(cmd_obs), 32'(C_NOP));
    bus_idle();
    @(negedge Clock);
    check("rd_dtack_release", 32'(Dtack_L), 32'd1);

    // Byte write, upper lane only
    AddressBusIn = 32'h0000_0012;
    DataBusIn    = 16'hBEEF;
    WE_L = 1'b0; UDS_L = 1'b0; LDS_L = 1'b1;
    DramSelect_L = 1'b0; AS_L = 1'b0;
    wait_cmd(C_ACTIVE, 400, n);
    check("wr_active_cmd", 32'(cmd_obs), 32'(C_ACTIVE));
    check("wr_active_row", 32'(SDram_Addr), 32'h0000);
    check("wr_active_ba", 32'(SDram_BA), 32'd0);
    repeat (2) @(negedge Clock);
    check("wr_write_cmd", 32'(cmd_obs), 32'(C_WRITE));
    check("wr_write_addr", 32'(SDram_Addr), 32'h0409);
    check("wr_write_dqm", 32'(SDram_DQM), 32'b01);
    check("wr_write_data", 32'(SDram_DQ_Out), 32'hBEEF);
    check("wr_write_oe", 32'(SDram_DQ_OE_H), 32'd1);
    check("wr_write_dtack", 32'(Dtack_L), 32'd1);
    @(negedge Clock);
    check("wr_after_oe", 32'(SDram_DQ_OE_H), 32'd0);
    check("wr_after_dtack", 32'(Dtack_L), 32'd0);
    check("wr_after_cmd", 32'(cmd_obs), 32'(C_NOP));
    repeat (5) @(negedge Clock);
    check("wr_hold_dtack", 32'(Dtack_L), 32'd0);
    bus_idle();
    @(negedge Clock);
    check("wr_dtack_release", 32'(Dtack_L), 32'd1);

    // Reset asserted four clocks after READ
    AddressBusIn = 32'h0080_2A30;
    WE_L = 1'b1; UDS_L = 1'b0; LDS_L = 1'b0;
    DramSelect_L = 1'b0; AS_L = 1'b0;
    wait_cmd(C_ACTIVE, 400, n);
    check("mid_active_cmd", 32'(cmd_obs), 32'(C_ACTIVE));
    repeat (2) @(negedge Clock);
    check("mid_read_cmd", 32'(cmd_obs), 32'(C_READ));
    repeat (4) @(posedge Clock);
    #1;
    Reset_L = 1'b0;
    #1;
    check_reset_outputs("mid");
    bus_idle();
    @(negedge Clock);
    Reset_L = 1'b1;
    wait_cmd(C_PRECHARGE, 6000, n);
    check("mid_restart_precharge", 32'(cmd_obs), 32'(C_PRECHARGE));
    check("mid_restart_nop_clocks", n, 5000 + 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/m68k_sdram_burst_controller.md
# m68k_sdram_burst_controller

Responder side of the cache-to-DRAM interface: accepts 8-word cache-line burst reads and single-word writes from the 68k cache controller and sequences a 16-bit SDRAM (4 banks, 13-bit row, 10-bit column, CAS latency 2). It also owns power-up initialisation and periodic auto-refresh. It sits between the cache controller and the SDRAM pins.

## Interface
Parameters:
- INIT_DELAY, 5000: clocks of NOP after reset before init commands (100 µs at 50 MHz).
- REFRESH_INTERVAL, 375: clocks between refresh requests.
- T_RCD, 2: clocks from ACTIVE to READ/WRITE.
- T_RP, 2: precharge-to-ACTIVE clocks.
- T_RC, 7: clocks from AUTO REFRESH to the next command.
- T_WR_RP, 3: clocks from WRITE (auto-precharge) to the next ACTIVE.
- All values must fit in 16 bits.

Ports:
- Clock in 1: system clock; all state changes on the rising edge.
- Reset_L in 1: asynchronous, active-low reset.
- AddressBusIn in 32: byte address from the cache controller.
- DataBusIn in 16: write data.
- DataBusOut out 16: read data to the cache.
- DramSelect_L, AS_L, WE_L, UDS_L, LDS_L in 1 each: access request, strobe, write, and byte lanes.
- Dtack_L out 1: acknowledge.
- SDram_CKE_H, SDram_CS_L, SDram_RAS_L, SDram_CAS_L, SDram_WE_L out 1 each: SDRAM control.
- SDram_BA out 2: bank.
- SDram_Addr out 13: row, column, or mode value.
- SDram_DQM out 2: byte masks; [1] is the upper byte.
- SDram_DQ_Out out 16 and SDram_DQ_OE_H out 1: write data and tristate enable.
- SDram_DQ_In in 16: read data.
- ControllerState out 5: debug only.

## Operation
- **Address map:** column = A[10:1]; bank = A[12:11]; row = A[25:13]; A[31:26] are ignored.
- **Commands:** encoded as {CS,RAS,CAS,WE}.
  - NOP 0111, ACTIVE 0011, READ 0101, WRITE 0100, PRECHARGE 0010, REFRESH 0001, LOAD MODE 0000.
  - READ and WRITE always drive SDram_Addr[10]=1 (auto-precharge).
- **Init sequence:**
  - InitWait: NOP for INIT_DELAY clocks.
  - InitPrecharge: PRECHARGE ALL (Addr[10]=1), then T_RP clocks of NOP.
  - InitRefresh1 and InitRefresh2: each is REFRESH followed by T_RC clocks of NOP.
  - InitLoadMode: LOAD MODE with Addr=13'h0223 (burst 8, sequential, CL2, single-location write), BA=00, then 2 NOPs.
  - Then Idle.
- **Idle:**
  - If refresh is pending, go to Refresh. Refresh has priority over a simultaneous request.
  - Otherwise, if DramSelect_L=0 and AS_L=0, go to Activate.
- **Refresh:** issue REFRESH, clear the pending flag, wait T_RC clocks, return to Idle.
- **Activate:** issue ACTIVE with row/bank, then T_RCD−1 NOP clocks; then WE_L selects ReadCmd or WriteCmd.
- **ReadCmd:** issue READ with column A[10:1]; A[3:1] arrive as 000 from the cache.
- **ReadBurst:** 8 data beats, then T_RP NOP clocks.
- **WriteCmd:** issue WRITE with DQM={UDS_L,LDS_L}, DQ_Out=DataBusIn, DQ_OE_H=1 for this cycle only; then T_WR_RP NOP clocks.
- **WaitAsHigh:** holds until AS_L=1, then goes to Idle. The next request is not recognised until AS_L has been seen high.
- **Refresh timer:** 16-bit counter runs continuously after InitLoadMode.
  - On reaching REFRESH_INTERVAL−1 it sets pending and wraps to 0.
  - A second expiry while pending is still set is absorbed (no queueing).
- **Reset mid-operation:** abandons any access immediately and restarts the init sequence from InitWait.
- **Reset values:**
  - CKE_H=1, command=NOP, BA=0, Addr=0, DQM=11, DQ_Out=0, DQ_OE_H=0, Dtack_L=1.
  - Refresh timer and pending flag cleared.

## Timing
- **Reads:**
  - ACTIVE at cycle T; READ at T+T_RCD.
  - DataBusOut = SDram_DQ_In combinationally; beat k (0..7) is valid at T+T_RCD+2+k.
  - Dtack_L goes low the cycle READ is issued and stays low until AS_L=1.
  - DQM=00 throughout the read.
- **Writes:**
  - WRITE at T+T_RCD.
  - Dtack_L goes low at T+T_RCD+1 and stays low until AS_L=1.
- **Refresh blocking:** a pending refresh delays Activate by at most T_RC+1 clocks.
- **Outputs:** all SDRAM outputs are registered; command pins never glitch between clocks.

## Configuration
- SDRAM_REFRESH_EN defined: periodic refresh timer and the Refresh state are active.
- SDRAM_REFRESH_EN undefined:
  - The timer is removed and pending is tied to 0; Idle never enters Refresh.
  - The two init refreshes are still issued.
  - For short simulations only.

## Test plan
- **Init:** release Reset_L.
  - NOP for 5000 clocks, then PRECHARGE (Addr[10]=1), REFRESH, REFRESH spaced T_RC apart.
  - Then LOAD MODE with Addr=13'h0223, then Idle.
- **Burst read:** address 32'h0080_2A30, WE_L=1.
  - ACTIVE with row=13'h0401, BA=01; READ 2 clocks later with col=10'h118, Addr[10]=1.
  - 8 DQ_In words appear on DataBusOut at READ+2..READ+9.
  - Dtack_L low from READ until AS_L high.
- **Byte write:** address 32'h0000_0012, data 16'hBEEF, UDS_L=0, LDS_L=1.
  - WRITE with col=10'h009, DQM=01, DQ_OE_H=1 for one clock.
  - Dtack_L low one clock later.
- **Refresh collision:** refresh pending and request in the same Idle cycle.
  - REFRESH is issued first; ACTIVE follows T_RC clocks later.
- **Reset mid-burst:** assert Reset_L at READ+4.
  - Outputs return to reset values asynchronously; init restarts from InitWait.
- **Refresh cadence** (SDRAM_REFRESH_EN defined, bus idle): one REFRESH every 375 clocks.
